// File: rtl/tx_bit_driver_if.sv
// Signal bundle between the tx state machine / FIFO side and the tx bit driver.
// The master modport is the upstream FSM + FIFO; the slave modport is the bit driver.
interface tx_bit_driver_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [4:0]            State_i;
  logic [3:0]            BitCounter_i;
  logic                  p_BaudSig_i;
  logic                  p_ParityCalTrigger_i;
  logic                  ParityOdd_i;
  logic [DATA_WIDTH-1:0] FifoData_i;
  logic                  p_FifoRd_o;
  logic                  Tx_o;
  logic                  ParityBit_o;
  logic                  p_TxDone_o;
  logic                  p_StateErr_o;
  logic [CNT_WIDTH-1:0]  TxCount_o;

  modport master (
    output State_i, BitCounter_i, p_BaudSig_i, p_ParityCalTrigger_i, ParityOdd_i, FifoData_i,
    input  p_FifoRd_o, Tx_o, ParityBit_o, p_TxDone_o, p_StateErr_o, TxCount_o
  );

  modport slave (
    input  State_i, BitCounter_i, p_BaudSig_i, p_ParityCalTrigger_i, ParityOdd_i, FifoData_i,
    output p_FifoRd_o, Tx_o, ParityBit_o, p_TxDone_o, p_StateErr_o, TxCount_o
  );
endinterface

// File: rtl/tx_bit_driver.sv
// Transmit bit driver: pops one FIFO byte per frame, computes parity, drives the
// registered serial line and counts completed frames.
module tx_bit_driver #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input logic           clk,
  input logic           rst,
  tx_bit_driver_if.slave bus
);

  localparam logic [4:0] ST_INTERVAL  = 5'b00001;
  localparam logic [4:0] ST_STARTBIT  = 5'b00010;
  localparam logic [4:0] ST_DATABITS  = 5'b00100;
  localparam logic [4:0] ST_PARITYBIT = 5'b01000;
  localparam logic [4:0] ST_STOPBIT   = 5'b10000;

  logic [4:0]            state_p1;
  logic                  fifo_rd_p1;
  logic                  load_pend_p1;
  logic [DATA_WIDTH-1:0] data_lat;
  logic                  parity_p1;
  logic                  tx_p1;
  logic                  done_p1;
  logic                  err_p1;
  logic [CNT_WIDTH-1:0]  cnt_p1;

  logic                  start_entry;
  logic [DATA_WIDTH-1:0] data_sh;
  logic [31:0]           bit_idx;

  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

  // Out-of-range bit indices idle the line high rather than wrapping into the byte.
  function automatic logic data_level(input logic [DATA_WIDTH-1:0] shifted, input logic [31:0] idx);
    return (idx < 32'(DATA_WIDTH)) ? shifted[0] : 1'b1;
  endfunction

  assign start_entry = (bus.State_i == ST_STARTBIT) && (state_p1 != ST_STARTBIT);
  assign data_sh     = data_lat >> bus.BitCounter_i;
  assign bit_idx     = 32'(bus.BitCounter_i);

  // Stage p1: FIFO handshake, data latch, parity and line level all registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p1     <= ST_INTERVAL;
      fifo_rd_p1   <= 1'b0;
      load_pend_p1 <= 1'b0;
      data_lat     <= '0;
      parity_p1    <= 1'b0;
      tx_p1        <= 1'b1;
      done_p1      <= 1'b0;
      err_p1       <= 1'b0;
      cnt_p1       <= '0;
    end else begin
      state_p1   <= bus.State_i;
      fifo_rd_p1 <= start_entry;

      // FIFO data is valid the cycle after the read strobe, whatever the state is by then.
      if (load_pend_p1) begin
        data_lat     <= bus.FifoData_i;
        load_pend_p1 <= 1'b0;
      end
      if (start_entry) begin
        load_pend_p1 <= 1'b1;
      end

      if (bus.p_ParityCalTrigger_i) begin
        parity_p1 <= calc_parity(data_lat, bus.ParityOdd_i);
      end

      err_p1 <= !$onehot(bus.State_i);
      case (bus.State_i)
        ST_INTERVAL:  tx_p1 <= 1'b1;
        ST_STARTBIT:  tx_p1 <= 1'b0;
        ST_DATABITS:  tx_p1 <= data_level(data_sh, bit_idx);
        ST_PARITYBIT: tx_p1 <= parity_p1;
        ST_STOPBIT:   tx_p1 <= 1'b1;
        default:      tx_p1 <= 1'b1;
      endcase

      done_p1 <= (bus.State_i == ST_STOPBIT) && bus.p_BaudSig_i;
      if ((bus.State_i == ST_STOPBIT) && bus.p_BaudSig_i) begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
    end
  end

  assign bus.p_FifoRd_o   = fifo_rd_p1;
  assign bus.Tx_o         = tx_p1;
  assign bus.ParityBit_o  = parity_p1;
  assign bus.p_TxDone_o   = done_p1;
  assign bus.p_StateErr_o = err_p1;
  assign bus.TxCount_o    = cnt_p1;

endmodule

// File: tb/tb_tx_bit_driver.sv
// Randomized bench for tx_bit_driver: frames are modelled as serial bit lists and
// compared cycle by cycle against the driven line and strobes.
module tb_tx_bit_driver;

  localparam int DW = 8;
  localparam int CW = 4;
  localparam logic [4:0] S_INT = 5'b00001;
  localparam logic [4:0] S_STA = 5'b00010;
  localparam logic [4:0] S_DAT = 5'b00100;
  localparam logic [4:0] S_PAR = 5'b01000;
  localparam logic [4:0] S_STO = 5'b10000;

  logic clk;
  logic rst;

  tx_bit_driver_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  tx_bit_driver #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec;
  int n_bad;
  int rd_seen;
  int m_cnt;
  logic m_par;
  logic e_tx, e_rd, e_done, e_err;
  logic [DW-1:0] fifo_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] st, input logic [3:0] bc, input logic bs,
                       input logic trig, input logic odd, input logic etx,
                       input logic erd, input logic edone);
    bus.State_i              = st;
    bus.BitCounter_i         = bc;
    bus.p_BaudSig_i          = bs;
    bus.p_ParityCalTrigger_i = trig;
    bus.ParityOdd_i          = odd;
    e_tx   = etx;
    e_rd   = erd;
    e_done = edone;
    e_err  = ($countones(st) != 1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("tx",     32'(bus.Tx_o),         32'(e_tx));
    chk("fifo_rd", 32'(bus.p_FifoRd_o),  32'(e_rd));
    chk("done",   32'(bus.p_TxDone_o),   32'(e_done));
    chk("st_err", 32'(bus.p_StateErr_o), 32'(e_err));
    chk("parity", 32'(bus.ParityBit_o),  32'(m_par));
    chk("count",  32'(bus.TxCount_o),    32'(m_cnt));
    if (bus.p_FifoRd_o === 1'b1) begin
      rd_seen++;
      bus.FifoData_i = (fifo_q.size() > 0) ? fifo_q.pop_front() : DW'($urandom);
    end else begin
      bus.FifoData_i = DW'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    fifo_q.delete();
    m_cnt = 0;
    m_par = 1'b0;
    for (int i = 0; i < n; i++) begin
      drive(S_INT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(S_INT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
  endtask

  // A frame is the serial list start, data LSB first, optional parity, stop.
  task automatic send_frame(input logic [DW-1:0] b, input logic odd, input logic pen,
                            input int baud, input int gap, input int abort_seg);
    logic fb[0:10];
    int nseg;
    logic [4:0] st;
    logic [3:0] bc;
    logic bs, trig, edone;
    fb[0] = 1'b0;
    for (int i = 0; i < DW; i++) fb[i+1] = b[i];
    if (pen) begin
      fb[9]  = (^b) ^ odd;
      fb[10] = 1'b1;
      nseg   = 11;
    end else begin
      fb[9]  = 1'b1;
      fb[10] = 1'b1;
      nseg   = 10;
    end
    fifo_q.push_back(b);
    rd_seen = 0;
    for (int seg = 0; seg < nseg; seg++) begin
      if (seg == 0)              begin st = S_STA; bc = 4'd0; end
      else if (seg <= DW)        begin st = S_DAT; bc = 4'(seg - 1); end
      else if (seg == nseg - 1)  begin st = S_STO; bc = 4'd0; end
      else                       begin st = S_PAR; bc = 4'd0; end
      for (int c = 0; c < baud; c++) begin
        if (seg == abort_seg && c == 1) begin
          do_reset(1);
          idle(2 * baud);
          return;
        end
        bs    = (c == baud - 1);
        trig  = (seg == 1) && bs;
        edone = (st == S_STO) && bs;
        if (trig)  m_par = (^b) ^ odd;
        if (edone) m_cnt = (m_cnt + 1) % (1 << CW);
        drive(st, bc, bs, trig, odd, fb[seg], (seg == 0 && c == 0), edone);
        tick();
      end
    end
    idle(gap);
    chk("reads_per_frame", 32'(rd_seen), 32'd1);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_vec = 0;
    n_bad = 0;
    rd_seen = 0;
    m_cnt = 0;
    m_par = 1'b0;
    bus.FifoData_i = '0;
    drive(S_INT, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    do_reset(2);
    idle(3);

    send_frame(8'hA5, 1'b0, 1'b1, 16, 4, -1);
    chk("count_after_a5", 32'(bus.TxCount_o), 32'd1);

    send_frame(8'h01, 1'b1, 1'b1, 5, 3, -1);
    chk("par_odd_01", 32'(bus.ParityBit_o), 32'd0);
    send_frame(8'h01, 1'b0, 1'b1, 5, 3, -1);
    chk("par_even_01", 32'(bus.ParityBit_o), 32'd1);

    send_frame(8'h3C, 1'b0, 1'b1, 4, 1, -1);
    send_frame(8'hFF, 1'b0, 1'b1, 4, 3, -1);
    chk("count_b2b", 32'(bus.TxCount_o), 32'd5);

    // Illegal one-hot value, then out-of-range data bit index.
    drive(5'b00110, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    idle(2);
    for (int i = DW; i < 16; i++) begin
      drive(S_DAT, 4'(i), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    idle(2);

    // Eleven more frames bring the 4-bit counter to 16 and wrap it to zero.
    for (int f = 0; f < 11; f++) begin
      send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(3, 8), $urandom_range(1, 4), -1);
    end
    chk("count_wrap", 32'(bus.TxCount_o), 32'd0);

    for (int f = 0; f < 6; f++) begin
      send_frame(DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(3, 8), $urandom_range(1, 4), -1);
    end

    send_frame(8'h5A, 1'b1, 1'b1, 8, 2, 3);
    chk("count_after_abort", 32'(bus.TxCount_o), 32'd0);

    send_frame(8'hC3, 1'b1, 1'b1, 6, 3, -1);
    chk("count_after_recovery", 32'(bus.TxCount_o), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tx_bit_driver.md
Name: tx_bit_driver

Overview:
- Transmit datapath stage directly downstream of the transmit state machine.
- Consumes its one-hot state, data-bit index, parity trigger and baud strobe.
- Pops one byte from the transmit FIFO per frame, latches it, and computes the parity bit.
- Drives the serial tx line, pulses frame-done, and keeps a running count of frames sent.

Parameters:
- DATA_WIDTH, 8: data bits per frame. BitCounter_i indexes bits 0..DATA_WIDTH-1.
- CNT_WIDTH, 16: width of the transmitted-frame counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- State_i  input  5  one-hot state from the tx state machine: INTERVAL=00001, STARTBIT=00010, DATABITS=00100, PARITYBIT=01000, STOPBIT=10000
- BitCounter_i  input  4  index of the data bit currently on the wire
- p_BaudSig_i  input  1  baud strobe, 1 clk wide
- p_ParityCalTrigger_i  input  1  strobe: DATABITS, bit 0, baud edge
- ParityOdd_i  input  1  1 = odd parity, 0 = even parity
- FifoData_i  input  DATA_WIDTH  FIFO read data, valid exactly 1 clk after p_FifoRd_o
- p_FifoRd_o  output  1  FIFO read strobe, 1 clk wide
- Tx_o  output  1  serial tx line, registered
- ParityBit_o  output  1  computed parity bit
- p_TxDone_o  output  1  frame-complete strobe, 1 clk wide
- p_StateErr_o  output  1  strobe when State_i is not one-hot
- TxCount_o  output  CNT_WIDTH  frames completed

Behaviour:
- Reset, synchronous and active-high, takes effect at the next clk edge:
  - Tx_o=1.
  - p_FifoRd_o, p_TxDone_o and p_StateErr_o = 0.
  - ParityBit_o=0, TxCount_o=0.
  - Data latch = 0, load-pending = 0, previous-state register = INTERVAL.
- FIFO read:
  - Keep a registered copy of State_i.
  - When State_i==STARTBIT and the previous state != STARTBIT, assert p_FifoRd_o for exactly 1 clk.
  - Set load-pending in the same edge.
- Data latch:
  - On the clk after p_FifoRd_o, capture FifoData_i into the data latch and clear load-pending.
  - The load completes even if State_i has left STARTBIT in the meantime.
  - Exactly one read and one load occur per STARTBIT entry.
- Parity:
  - On p_ParityCalTrigger_i=1, ParityBit_o <= (XOR of data latch) XOR ParityOdd_i.
  - ParityBit_o holds until the next trigger.
  - The trigger comes at least one baud period after STARTBIT entry, so the latch is already loaded when the trigger arrives.
- Tx_o, registered, 1 clk latency from State_i:
  - INTERVAL: 1.
  - STARTBIT: 0.
  - DATABITS: data latch[BitCounter_i], LSB first. If BitCounter_i >= DATA_WIDTH, drive 1.
  - PARITYBIT: ParityBit_o.
  - STOPBIT: 1.
  - Any non-one-hot value: 1, and p_StateErr_o=1 for that cycle.
- Frame done:
  - When State_i==STOPBIT and p_BaudSig_i=1, p_TxDone_o=1 for the next cycle.
  - TxCount_o increments by 1 in the same edge, wrapping from 2^CNT_WIDTH-1 to 0.
- Reset mid-frame: Tx_o returns to 1 on the next edge. A pending load is discarded. TxCount_o clears.
- STOPBIT entered directly from DATABITS (parity disabled upstream): no special handling; ParityBit_o is simply unused.
- Timing: the baud period must be >= 3 clk so the read and load finish inside STARTBIT. A shorter period is not supported.

Test Plan:
- Reset: hold rst=1 for 2 clk with State_i=INTERVAL -> Tx_o=1, TxCount_o=0, all strobes 0 from the first edge.
- Single frame 0xA5, even parity, baud = 16 clk: FSM sequence INTERVAL→STARTBIT→DATABITS×8→PARITYBIT→STOPBIT→INTERVAL.
  - One p_FifoRd_o pulse.
  - Tx_o = 0,1,0,1,0,0,1,0,1, then parity 0, then 1, each lagging State_i/BitCounter_i by 1 clk.
  - p_TxDone_o pulses once; TxCount_o=1.
- Odd parity, byte 0x01: ParityBit_o=0 after the trigger. Repeat with even parity -> ParityBit_o=1.
- Back-to-back frames: STOPBIT→INTERVAL→STARTBIT within 2 baud periods, bytes 0x3C then 0xFF.
  - Exactly two p_FifoRd_o pulses.
  - The second frame's data bits are all 1.
  - TxCount_o=2.
- Illegal state: State_i=00110 for 1 clk -> Tx_o=1 and p_StateErr_o=1 for 1 clk. Next state INTERVAL -> p_StateErr_o=0.
- Counter wrap and reset mid-frame:
  - Preload 65535 completed frames (or use CNT_WIDTH=4 with 15 frames); one more frame -> TxCount_o=0.
  - Assert rst during DATABITS -> Tx_o=1 next edge and no p_TxDone_o afterwards.
